pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage pipeline. It sequences the EX stage around three events:
- load-use hazards, which stall IF/ID for one cycle and inject a bubble into ID/EX;
- taken branches resolved in EX, which flush IF/ID and ID/EX;
- multi-cycle EX operations (mult/div), which freeze IF, ID and ID/EX for MC_LATENCY-1 cycles while EX/MEM receives bubbles.

It also keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
MC_LATENCY, 4, total EX cycles for a multi-cycle op; legal range 1..255; 1 = no stall.
CNT_W, 16, width of StallCount.

Ports:
Clk  input  1  pipeline clock; all state updates on posedge.
Rst_n  input  1  asynchronous active-low reset.
IdRs  input  5  rs field of the instruction in ID.
IdRt  input  5  rt field of the instruction in ID.
IdUsesRs  input  1  ID instruction reads rs.
IdUsesRt  input  1  ID instruction reads rt.
ExMemRead  input  1  instruction in EX is a load.
ExRd  input  5  destination register of the instruction in EX.
ExMultiCycle  input  1  instruction in EX is a multi-cycle op.
BranchTaken  input  1  branch in EX resolved taken this cycle.
PCWrite  output  1  PC enable.
IFIDWrite  output  1  IF/ID register enable.
IFIDFlush  output  1  load NOP into IF/ID.
IDEXWrite  output  1  ID/EX register enable.
IDEXBubble  output  1  zero control bits entering ID/EX.
EXMEMBubble  output  1  zero RegWrite/MemRead/MemWrite entering EX/MEM.
Busy  output  1  multi-cycle sequence in progress.
StallCount  output  CNT_W  cycles with PCWrite=0 since reset; saturating.

Behaviour:
- Registered state: FSM {RUN, MC_BUSY, MC_DONE}, 8-bit Cnt, StallCount. All outputs other than StallCount are combinational from state and inputs.
- Reset (Rst_n=0, async, combinational override of outputs):
  - state=RUN, Cnt=0, StallCount=0.
  - PCWrite=0, IFIDWrite=0, IDEXWrite=0, IFIDFlush=0, IDEXBubble=1, EXMEMBubble=1, Busy=0.
- Default (no event): PCWrite=IFIDWrite=IDEXWrite=1, all flush/bubble outputs 0.
- LU = ExMemRead & (ExRd!=0) & ((IdUsesRs & ExRd==IdRs) | (IdUsesRt & ExRd==IdRt)).
- RUN, priority order:
  1. BranchTaken: IFIDFlush=1, IDEXBubble=1, PCWrite=1, IFIDWrite=1. ExMultiCycle and LU are ignored. Stay in RUN.
  2. ExMultiCycle & MC_LATENCY>1 ("trigger"): PCWrite=0, IFIDWrite=0, IDEXWrite=0, EXMEMBubble=1. Then Cnt<=MC_LATENCY-2; next state = MC_DONE if MC_LATENCY==2, else MC_BUSY.
  3. LU: PCWrite=0, IFIDWrite=0, IDEXBubble=1, IDEXWrite=1. Stay in RUN; the hazard clears naturally on the next cycle.
  4. Otherwise: default outputs.
- MC_BUSY:
  - Outputs same as trigger; Busy=1.
  - If Cnt==1, go to MC_DONE; else Cnt<=Cnt-1.
  - BranchTaken and LU are ignored (EX is occupied).
- MC_DONE:
  - Default outputs; Busy=1. EX/MEM captures the op result this cycle.
  - ExMultiCycle is ignored (same instruction still in EX).
  - BranchTaken and LU are evaluated as in RUN.
  - Next state is unconditionally RUN.
- Stall cycles per multi-cycle op = MC_LATENCY-1 exactly. Back-to-back multi-cycle ops re-trigger in the RUN cycle after MC_DONE.
- StallCount increments each posedge where PCWrite==0 and Rst_n==1; it holds at all-ones.
- Reset asserted mid-sequence aborts it immediately; the first post-reset cycle is RUN with Cnt=0.
- X on inputs while in MC_BUSY must not affect outputs.

Test Plan:
1. Reset: Rst_n=0 for 3 cycles, then release with quiet inputs -> during reset PCWrite=0, IDEXBubble=1, EXMEMBubble=1, StallCount=0; after release PCWrite=1, all bubble/flush outputs 0, Busy=0.
2. Load-use: ExMemRead=1, ExRd=8, IdRs=8, IdUsesRs=1 for one cycle -> PCWrite=0, IFIDWrite=0, IDEXBubble=1 for that cycle; StallCount=1. Repeat with ExRd=0 -> no stall. Repeat with IdUsesRs=0 -> no stall.
3. Branch priority: BranchTaken=1 together with LU conditions -> IFIDFlush=1, IDEXBubble=1, PCWrite=1; StallCount unchanged.
4. Multi-cycle, MC_LATENCY=4: ExMultiCycle held high ->
   - 3 stall cycles with EXMEMBubble=1 and IDEXWrite=0;
   - then one MC_DONE cycle with PCWrite=1 and Busy=1;
   - then RUN; StallCount=3.
   Same with MC_LATENCY=2 -> 1 stall cycle. MC_LATENCY=1 -> no stall.
5. Reset mid-op: assert Rst_n=0 during the second MC_BUSY cycle -> outputs immediately take reset values; after release state=RUN, Busy=0, StallCount=0.
6. Saturation: CNT_W=4, hold LU for 20 cycles -> StallCount stops at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use bubbles, branch
// flushes and multi-cycle EX freezes, plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int unsigned MC_LATENCY = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [4:0]       IdRs,
  input  logic [4:0]       IdRt,
  input  logic             IdUsesRs,
  input  logic             IdUsesRt,
  input  logic             ExMemRead,
  input  logic [4:0]       ExRd,
  input  logic             ExMultiCycle,
  input  logic             BranchTaken,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXWrite,
  output logic             IDEXBubble,
  output logic             EXMEMBubble,
  output logic             Busy,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic [1:0] {RUN, MC_BUSY, MC_DONE} state_e;

  localparam bit         MC_STALLS = (MC_LATENCY > 1);
  localparam bit         MC_SHORT  = (MC_LATENCY == 2);
  localparam logic [7:0] MC_RELOAD = MC_STALLS ? 8'(MC_LATENCY - 2) : 8'd0;

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use;

  assign load_use = ExMemRead && (ExRd != 5'd0) &&
                    ((IdUsesRs && (ExRd == IdRs)) || (IdUsesRt && (ExRd == IdRt)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IDEXWrite   = 1'b1;
    IFIDFlush   = 1'b0;
    IDEXBubble  = 1'b0;
    EXMEMBubble = 1'b0;
    Busy        = 1'b0;

    unique case (state_q)
      RUN: begin
        if (BranchTaken) begin
          IFIDFlush  = 1'b1;
          IDEXBubble = 1'b1;
        end else if (ExMultiCycle && MC_STALLS) begin
          PCWrite     = 1'b0;
          IFIDWrite   = 1'b0;
          IDEXWrite   = 1'b0;
          EXMEMBubble = 1'b1;
          cnt_d       = MC_RELOAD;
          state_d     = MC_SHORT ? MC_DONE : MC_BUSY;
        end else if (load_use) begin
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          IDEXBubble = 1'b1;
        end
      end
      // EX is occupied: nothing but the countdown may influence outputs here.
      MC_BUSY: begin
        PCWrite     = 1'b0;
        IFIDWrite   = 1'b0;
        IDEXWrite   = 1'b0;
        EXMEMBubble = 1'b1;
        Busy        = 1'b1;
        if (cnt_q == 8'd1) begin
          state_d = MC_DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      MC_DONE: begin
        Busy    = 1'b1;
        state_d = RUN;
        if (BranchTaken) begin
          IFIDFlush  = 1'b1;
          IDEXBubble = 1'b1;
        end else if (load_use) begin
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          IDEXBubble = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if (!Rst_n) begin
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IDEXWrite   = 1'b0;
      IFIDFlush   = 1'b0;
      IDEXBubble  = 1'b1;
      EXMEMBubble = 1'b1;
      Busy        = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PCWrite && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;

endmodule
